// File: rtl/gpc_c2f_req_buf.sv
// rtl/gpc_c2f_req_buf.sv - C2F request FIFO toward the fabric with early stall (optional stats: C2F_REQ_BUF_STATS_EN)
module gpc_c2f_req_buf #(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                       QClk,
    input  logic                       RstQnnnH,
    input  logic                       C2F_ReqValidQ500H,
    input  logic [1:0]                 C2F_ReqOpcodeQ500H,
    input  logic [1:0]                 C2F_ReqThreadIDQ500H,
    input  logic [ADDR_W-1:0]          C2F_ReqAddressQ500H,
    input  logic [DATA_W-1:0]          C2F_ReqDataQ500H,
    output logic                       C2F_RspStall,
    output logic                       FabReqValidQ501H,
    output logic [1:0]                 FabReqOpcodeQ501H,
    output logic [1:0]                 FabReqThreadIDQ501H,
    output logic [ADDR_W-1:0]          FabReqAddressQ501H,
    output logic [DATA_W-1:0]          FabReqDataQ501H,
    input  logic                       FabReqReady,
    output logic [$clog2(DEPTH+1)-1:0] BufCount,
    output logic                       BufOvfErr
`ifdef C2F_REQ_BUF_STATS_EN
    ,
    output logic [15:0]                StatPushCnt,
    output logic [15:0]                StatStallCycCnt,
    output logic [$clog2(DEPTH+1)-1:0] StatMaxOcc
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - STALL_MARGIN);

    logic [1:0]        op_mem   [DEPTH];
    logic [1:0]        tid_mem  [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             stall_q;
    logic             ovf_q;
    logic             buf_valid;
    logic             push;
    logic             pop;
    logic             ovf;

    assign buf_valid = (cnt != '0);
    assign pop       = buf_valid && FabReqReady;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign push      = C2F_ReqValidQ500H && ((cnt != CNT_FULL) || pop);
    assign ovf       = C2F_ReqValidQ500H && (cnt == CNT_FULL) && !pop;

    // Occupancy after this cycle's push/pop
    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Pointers, occupancy, registered stall and sticky overflow
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt     <= cnt_nxt;
            stall_q <= (cnt_nxt >= CNT_STALL);
            if (ovf) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Entry storage; contents are meaningless until covered by the pointers
    always_ff @(posedge QClk) begin
        if (push) begin
            op_mem[wr_ptr]   <= C2F_ReqOpcodeQ500H;
            tid_mem[wr_ptr]  <= C2F_ReqThreadIDQ500H;
            addr_mem[wr_ptr] <= C2F_ReqAddressQ500H;
            data_mem[wr_ptr] <= C2F_ReqDataQ500H;
        end
    end

    assign C2F_RspStall        = stall_q;
    assign BufOvfErr           = ovf_q;
    assign BufCount            = cnt;
    assign FabReqValidQ501H    = buf_valid;
    assign FabReqOpcodeQ501H   = buf_valid ? op_mem[rd_ptr]   : '0;
    assign FabReqThreadIDQ501H = buf_valid ? tid_mem[rd_ptr]  : '0;
    assign FabReqAddressQ501H  = buf_valid ? addr_mem[rd_ptr] : '0;
    assign FabReqDataQ501H     = buf_valid ? data_mem[rd_ptr] : '0;

`ifdef C2F_REQ_BUF_STATS_EN
    logic [15:0]      push_cnt_q;
    logic [15:0]      stall_cyc_q;
    logic [CNT_W-1:0] max_occ_q;

    // Saturating push / stall-cycle counters and occupancy high-water mark
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            push_cnt_q  <= '0;
            stall_cyc_q <= '0;
            max_occ_q   <= '0;
        end else begin
            if (push && (push_cnt_q != 16'hFFFF)) begin
                push_cnt_q <= push_cnt_q + 16'd1;
            end
            if (stall_q && (stall_cyc_q != 16'hFFFF)) begin
                stall_cyc_q <= stall_cyc_q + 16'd1;
            end
            if (cnt_nxt > max_occ_q) begin
                max_occ_q <= cnt_nxt;
            end
        end
    end

    assign StatPushCnt     = push_cnt_q;
    assign StatStallCycCnt = stall_cyc_q;
    assign StatMaxOcc      = max_occ_q;
`endif

endmodule

// File: tb/tb_gpc_c2f_req_buf.sv
// tb/tb_gpc_c2f_req_buf.sv - scoreboard bench for gpc_c2f_req_buf (DEPTH=8, STALL_MARGIN=2)
module tb_gpc_c2f_req_buf;

    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  tid;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        c2f_valid;
    logic [1:0]  c2f_op;
    logic [1:0]  c2f_tid;
    logic [31:0] c2f_addr;
    logic [31:0] c2f_data;
    logic        stall;
    logic        fab_valid;
    logic [1:0]  fab_op;
    logic [1:0]  fab_tid;
    logic [31:0] fab_addr;
    logic [31:0] fab_data;
    logic        fab_ready;
    logic [3:0]  buf_count;
    logic        ovf_err;
`ifdef C2F_REQ_BUF_STATS_EN
    logic [15:0] stat_push;
    logic [15:0] stat_stall;
    logic [3:0]  stat_max;
`endif

    int    total = 0;
    int    bad   = 0;
    beat_t sb[$];
    int    mcnt;
    logic  m_stall;
    logic  m_ovf;
    int    m_stall_cyc;
    int    m_push_cnt;
    int    m_max;

    gpc_c2f_req_buf #(.DEPTH(8), .STALL_MARGIN(2), .ADDR_W(32), .DATA_W(32)) dut (
        .QClk                 (clk),
        .RstQnnnH             (rst),
        .C2F_ReqValidQ500H    (c2f_valid),
        .C2F_ReqOpcodeQ500H   (c2f_op),
        .C2F_ReqThreadIDQ500H (c2f_tid),
        .C2F_ReqAddressQ500H  (c2f_addr),
        .C2F_ReqDataQ500H     (c2f_data),
        .C2F_RspStall         (stall),
        .FabReqValidQ501H     (fab_valid),
        .FabReqOpcodeQ501H    (fab_op),
        .FabReqThreadIDQ501H  (fab_tid),
        .FabReqAddressQ501H   (fab_addr),
        .FabReqDataQ501H      (fab_data),
        .FabReqReady          (fab_ready),
        .BufCount             (buf_count),
        .BufOvfErr            (ovf_err)
`ifdef C2F_REQ_BUF_STATS_EN
        ,
        .StatPushCnt          (stat_push),
        .StatStallCycCnt      (stat_stall),
        .StatMaxOcc           (stat_max)
`endif
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input int i);
        beat_t b;
        b.op   = 2'(i % 4);
        b.tid  = 2'((i + 1) % 4);
        b.addr = 32'h1000_0000 + 32'(i * 4);
        b.data = $urandom;
        return b;
    endfunction

    // One clock: drive at negedge, score any pop, update model, return at next negedge
    task automatic step(input logic v, input beat_t b, input logic rdy);
        logic  m_pop;
        logic  m_push;
        beat_t exp;
        c2f_valid = v;
        c2f_op    = b.op;
        c2f_tid   = b.tid;
        c2f_addr  = b.addr;
        c2f_data  = b.data;
        fab_ready = rdy;
        total++;
        if (fab_valid !== (mcnt != 0)) begin
            bad++;
            $display("FAIL valid: got %b want %b", fab_valid, (mcnt != 0));
        end
        m_pop = (mcnt != 0) && rdy;
        if (m_pop) begin
            exp = sb.pop_front();
            total++;
            if ({fab_op, fab_tid, fab_addr, fab_data} !== exp) begin
                bad++;
                $display("FAIL head: got %h want %h", {fab_op, fab_tid, fab_addr, fab_data}, exp);
            end
        end
        m_push = v && ((mcnt < 8) || m_pop);
        if (m_push) begin
            sb.push_back(b);
            m_push_cnt++;
        end
        if (v && !m_push) m_ovf = 1'b1;
        mcnt = mcnt + int'(m_push) - int'(m_pop);
        if (m_stall) m_stall_cyc++;
        m_stall = (mcnt >= 6);
        if (mcnt > m_max) m_max = mcnt;
        @(posedge clk);
        @(negedge clk);
        c2f_valid = 1'b0;
        fab_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        c2f_valid = 1'b0;
        fab_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        sb.delete();
        mcnt        = 0;
        m_stall     = 1'b0;
        m_ovf       = 1'b0;
        m_stall_cyc = 0;
        m_push_cnt  = 0;
        m_max       = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && mcnt != 0; k++) begin
            step(1'b0, mk(0), 1'b1);
            total++;
            if (stall !== m_stall) begin
                bad++;
                $display("FAIL drain_stall: got %b want %b", stall, m_stall);
            end
        end
        total++;
        if (sb.size() != 0 || buf_count !== 4'd0) begin
            bad++;
            $display("FAIL drained: left %0d count %0d want 0", sb.size(), buf_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({fab_valid, stall, ovf_err, buf_count, fab_op, fab_tid, fab_addr, fab_data} !== '0) begin
            bad++;
            $display("FAIL reset: v=%b st=%b ovf=%b cnt=%0d data=%h want all 0",
                     fab_valid, stall, ovf_err, buf_count, fab_data);
        end
    endtask

    task automatic test_single();
        beat_t b;
        b = '{op: 2'd1, tid: 2'd2, addr: 32'h0040_0F00, data: 32'hDEAD_BEEF};
        step(1'b1, b, 1'b1);
        total++;
        if (fab_valid !== 1'b1 || {fab_op, fab_tid, fab_addr, fab_data} !== b || buf_count !== 4'd1) begin
            bad++;
            $display("FAIL single_n1: v=%b got %h cnt=%0d want %h cnt=1",
                     fab_valid, {fab_op, fab_tid, fab_addr, fab_data}, buf_count, b);
        end
        step(1'b0, mk(0), 1'b1);
        total++;
        if (buf_count !== 4'd0 || fab_valid !== 1'b0 || fab_data !== 32'd0) begin
            bad++;
            $display("FAIL single_n2: cnt=%0d v=%b data=%h want 0", buf_count, fab_valid, fab_data);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, mk(i), 1'b0);
            if (i == 5) begin
                total++;
                if (stall !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_early: got %b want 0", stall);
                end
            end
        end
        total++;
        if (stall !== 1'b1 || buf_count !== 4'd6) begin
            bad++;
            $display("FAIL stall_rise: st=%b cnt=%0d want 1/6", stall, buf_count);
        end
        step(1'b1, mk(7), 1'b0);
        step(1'b1, mk(8), 1'b0);
        total++;
        if (buf_count !== 4'd8 || ovf_err !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL margin: cnt=%0d ovf=%b st=%b want 8/0/1", buf_count, ovf_err, stall);
        end
    endtask

    task automatic test_overflow();
        step(1'b1, mk(100), 1'b0);
        total++;
        if (buf_count !== 4'd8 || ovf_err !== 1'b1 || m_ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow: cnt=%0d ovf=%b want 8/1", buf_count, ovf_err);
        end
        drain();
        total++;
        if (ovf_err !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got %b want 1", ovf_err);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, mk(200 + i), 1'b0);
        step(1'b1, mk(300), 1'b1);
        total++;
        if (buf_count !== 4'd8 || ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL full_pushpop: cnt=%0d ovf=%b want 8/0", buf_count, ovf_err);
        end
        step(1'b1, mk(301), 1'b1);
        step(1'b1, mk(302), 1'b1);
        drain();
    endtask

    task automatic test_reset_mid();
        beat_t b;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, mk(400 + i), 1'b0);
        do_reset();
        total++;
        if (buf_count !== 4'd0 || fab_valid !== 1'b0 || stall !== 1'b0 || ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: cnt=%0d v=%b st=%b ovf=%b want 0", buf_count, fab_valid, stall, ovf_err);
        end
        b = mk(500);
        step(1'b1, b, 1'b0);
        total++;
        if (fab_valid !== 1'b1 || {fab_op, fab_tid, fab_addr, fab_data} !== b) begin
            bad++;
            $display("FAIL post_reset: got %h want %h", {fab_op, fab_tid, fab_addr, fab_data}, b);
        end
        drain();
    endtask

`ifdef C2F_REQ_BUF_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, mk(600 + i), 1'b0);
        drain();
        total++;
        if (stat_push !== 16'(m_push_cnt) || stat_max !== 4'(m_max) || stat_stall !== 16'(m_stall_cyc)
            || m_push_cnt != 8 || m_max != 8) begin
            bad++;
            $display("FAIL stats: push=%0d max=%0d stallcyc=%0d want %0d/%0d/%0d",
                     stat_push, stat_max, stat_stall, m_push_cnt, m_max, m_stall_cyc);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        c2f_valid = 1'b0;
        c2f_op    = '0;
        c2f_tid   = '0;
        c2f_addr  = '0;
        c2f_data  = '0;
        fab_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
`ifdef C2F_REQ_BUF_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
